i2c_master_ctrl: RTL and testbench

- Clocked I2C master that sequences single-byte transactions on the shared open-drain sda/scl bus: START, 7-bit address + R/W, ACK check, one data byte, ACK/NACK, STOP.
- Sits between the system-side register/command logic and the I2C slaves in the design.
- Accepts one request at a time via a valid/ready handshake.
- Returns a one-cycle response pulse carrying read data and NACK status.

---
 rtl/i2c_master_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address + R/W, ACK, one data byte, ACK/NACK, STOP.
// scl/sda are open-drain: only ever pulled low or released, never driven high.
module i2c_master_ctrl #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic       req_rw,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  inout  wire        scl,
  inout  wire        sda
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StAddr,
    StAAck,
    StWdata,
    StWAck,
    StRdata,
    StMNack,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [2:0]      bit_q, bit_d;
  logic [6:0]      addr_q, addr_d;
  logic            rw_q, rw_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      rx_q, rx_d;
  logic            smp_q, smp_d;
  logic            nack_q, nack_d;
  logic            busy_q, busy_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_nack_q, rsp_nack_d;
  logic [7:0]      rsp_rdata_q, rsp_rdata_d;

  logic       tick, slot_end, sda_in, scl_low, sda_low, bit_scl_low;
  logic [7:0] addr_byte;

  assign tick        = (state_q != StIdle) && (div_q == DivMax);
  assign slot_end    = tick && (qtr_q == 2'd3);
  assign sda_in      = sda;
  assign addr_byte   = {addr_q, rw_q};
  assign bit_scl_low = (qtr_q == 2'd0) || (qtr_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      div_q       <= '0;
      qtr_q       <= '0;
      bit_q       <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      rx_q        <= '0;
      smp_q       <= 1'b0;
      nack_q      <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_nack_q  <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      qtr_q       <= qtr_d;
      bit_q       <= bit_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      rx_q        <= rx_d;
      smp_q       <= smp_d;
      nack_q      <= nack_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_nack_q  <= rsp_nack_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    qtr_d       = qtr_q;
    bit_d       = bit_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    rx_d        = rx_q;
    smp_d       = smp_q;
    nack_d      = nack_q;
    busy_d      = busy_q;
    rsp_valid_d = 1'b0;
    rsp_nack_d  = rsp_nack_q;
    rsp_rdata_d = rsp_rdata_q;

    if (state_q == StIdle) begin
      div_d = '0;
      qtr_d = '0;
      if (req_valid && req_ready) begin
        addr_d  = req_addr;
        rw_d    = req_rw;
        wdata_d = req_wdata;
        nack_d  = 1'b0;
        busy_d  = 1'b1;
        state_d = StStart;
      end
    end else begin
      div_d = tick ? '0 : div_q + DivW'(1);
      if (tick) begin
        qtr_d = qtr_q + 2'd1;
      end
      // sda is sampled on the last clock of q2, while scl is high
      if (tick && (qtr_q == 2'd2)) begin
        smp_d = sda_in;
        if (state_q == StRdata) begin
          rx_d = {rx_q[6:0], sda_in};
        end
      end
      if (slot_end) begin
        case (state_q)
          StStart: begin
            state_d = StAddr;
            bit_d   = 3'd7;
          end
          StAddr: begin
            bit_d = bit_q - 3'd1;
            if (bit_q == 3'd0) state_d = StAAck;
          end
          StAAck: begin
            if (smp_q) begin
              nack_d  = 1'b1;
              state_d = StStop;
            end else begin
              state_d = rw_q ? StRdata : StWdata;
            end
          end
          StWdata: begin
            bit_d = bit_q - 3'd1;
            if (bit_q == 3'd0) state_d = StWAck;
          end
          StWAck: begin
            if (smp_q) nack_d = 1'b1;
            state_d = StStop;
          end
          StRdata: begin
            bit_d = bit_q - 3'd1;
            if (bit_q == 3'd0) state_d = StMNack;
          end
          StMNack: state_d = StStop;
          StStop: begin
            state_d     = StIdle;
            busy_d      = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_nack_d  = nack_q;
            if (rw_q && !nack_q) rsp_rdata_d = rx_q;
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_comb begin
    scl_low = 1'b0;
    sda_low = 1'b0;
    case (state_q)
      StStart: begin
        sda_low = qtr_q[1];
        scl_low = (qtr_q == 2'd3);
      end
      StAddr: begin
        scl_low = bit_scl_low;
        sda_low = !addr_byte[bit_q];
      end
      StWdata: begin
        scl_low = bit_scl_low;
        sda_low = !wdata_q[bit_q];
      end
      StAAck, StWAck, StRdata, StMNack: scl_low = bit_scl_low;
      StStop: begin
        scl_low = (qtr_q == 2'd0);
        sda_low = !qtr_q[1];
      end
      default: ;
    endcase
  end

  assign scl = scl_low ? 1'b0 : 1'bz;
  assign sda = sda_low ? 1'b0 : 1'bz;

  // Holding off ready during the response cycle makes a held request land one clock later.
  assign req_ready = (state_q == StIdle) && !rsp_valid_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_nack  = rsp_nack_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: bus-level slave/monitor model plus a transaction-level reference
// that predicts response, latency, bus bytes and SCL phase lengths.
module tb_i2c_master_ctrl;

  localparam int unsigned Div     = 3;
  localparam logic [6:0]  SlvAddr = 7'h2A;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_addr;
  logic       req_rw;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       busy;
  wire        scl;
  wire        sda;

  pullup (scl);
  pullup (sda);

  i2c_master_ctrl #(
    .CLK_DIV (Div)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_rw    (req_rw),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_nack  (rsp_nack),
    .busy      (busy),
    .scl       (scl),
    .sda       (sda)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave configuration, written by the stimulus only.
  logic [7:0] slv_tx        = 8'h00;
  bit         slv_nack_data = 1'b0;
  bit         mon_en        = 1'b1;

  // Slave/monitor state, written by the monitor only.
  logic       slv_drv       = 1'b0;
  int         cyc_cnt       = 0;
  int         last_edge     = 0;
  bit         edge_ok       = 1'b0;
  bit         in_txn        = 1'b0;
  bit         p_scl         = 1'b1;
  bit         p_sda         = 1'b1;
  bit         addressed     = 1'b0;
  bit         rd_mode       = 1'b0;
  int         bitcnt        = 0;
  int         byte_idx      = 0;
  logic [7:0] shreg         = 8'h00;
  logic [7:0] slv_addr_byte = 8'h00;
  logic [7:0] slv_data_byte = 8'h00;
  int         slv_starts    = 0;
  int         slv_stops     = 0;
  int         slv_frames    = 0;
  int         slv_mnack     = 0;
  int         ph_edges      = 0;
  int         ph_bad        = 0;
  int         sda_edge_bad  = 0;
  int         proto_bad     = 0;

  assign sda = slv_drv ? 1'b0 : 1'bz;

  always @(negedge clk) begin
    logic s_scl, s_sda;
    s_scl = (scl !== 1'b0);
    s_sda = (sda !== 1'b0);
    cyc_cnt++;
    if (!mon_en) begin
      in_txn  = 1'b0;
      slv_drv = 1'b0;
      edge_ok = 1'b0;
    end else if (p_scl && s_scl && (p_sda != s_sda)) begin
      if (!s_sda) begin
        if (in_txn) proto_bad++;
        in_txn    = 1'b1;
        bitcnt    = 0;
        byte_idx  = 0;
        addressed = 1'b0;
        rd_mode   = 1'b0;
        edge_ok   = 1'b0;
        slv_starts++;
      end else begin
        if (!in_txn) proto_bad++;
        in_txn = 1'b0;
        slv_stops++;
      end
    end else if (p_scl != s_scl) begin
      if (p_sda != s_sda) sda_edge_bad++;
      if (edge_ok) begin
        ph_edges++;
        if ((cyc_cnt - last_edge) != int'(2 * Div)) ph_bad++;
      end
      edge_ok   = 1'b1;
      last_edge = cyc_cnt;
      if (in_txn && s_scl) begin
        if (bitcnt < 8) begin
          shreg = {shreg[6:0], s_sda};
          bitcnt++;
        end else if (bitcnt == 8) begin
          if (byte_idx == 1 && rd_mode && addressed && s_sda) slv_mnack++;
          bitcnt = 9;
        end
      end else if (in_txn) begin
        if (bitcnt == 8) begin
          if (byte_idx == 0) begin
            slv_addr_byte = shreg;
            addressed     = (shreg[7:1] == SlvAddr);
            rd_mode       = shreg[0];
            slv_drv       = addressed;
          end else if (!rd_mode) begin
            slv_data_byte = shreg;
            slv_drv       = !slv_nack_data;
          end else begin
            slv_drv = 1'b0;
          end
        end else if (bitcnt == 9) begin
          slv_frames++;
          byte_idx++;
          bitcnt  = 0;
          slv_drv = (byte_idx == 1 && rd_mode && addressed) ? !slv_tx[7] : 1'b0;
        end else if (byte_idx == 1 && rd_mode && addressed && bitcnt >= 1) begin
          slv_drv = !slv_tx[7-bitcnt];
        end
      end
    end
    p_scl = s_scl;
    p_sda = s_sda;
  end

  logic [7:0] m_rdata = 8'h00;

  // Issues one request from a negedge and waits for its response; exp_wait < 0 skips the
  // accept-delay check. keep_valid leaves req_valid asserted for a back-to-back follow-up.
  task automatic run_txn(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                         input bit keep_valid, input int exp_wait);
    int         waited, lat, exp_lat, st0, sp0, fr0, mn0, pe0, pb0, sb0, pr0;
    bit         ack_a, exp_nack;
    logic [7:0] exp_rd;
    st0 = slv_starts; sp0 = slv_stops; fr0 = slv_frames; mn0 = slv_mnack;
    pe0 = ph_edges;   pb0 = ph_bad;    sb0 = sda_edge_bad; pr0 = proto_bad;
    req_valid = 1'b1;
    req_addr  = a;
    req_rw    = rw;
    req_wdata = wd;
    waited    = 0;
    while (!req_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (exp_wait >= 0) check("accept_wait", 32'(waited), 32'(exp_wait));
    ack_a    = (a == SlvAddr);
    exp_nack = !ack_a || (!rw && slv_nack_data);
    exp_rd   = (rw && ack_a) ? slv_tx : m_rdata;
    exp_lat  = ack_a ? int'(80 * Div + 1) : int'(44 * Div + 1);
    lat      = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("busy_after_accept", 32'(busy), 32'd1);
        check("ready_while_busy", 32'(req_ready), 32'd0);
      end
      req_addr  = 7'($urandom);
      req_rw    = 1'($urandom);
      req_wdata = 8'($urandom);
    end while (!rsp_valid && lat < int'(100 * Div + 20));
    check("rsp_latency", 32'(lat), 32'(exp_lat));
    check("rsp_nack", 32'(rsp_nack), 32'(exp_nack));
    check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
    check("busy_at_rsp", 32'(busy), 32'd0);
    check("bus_idle", {30'd0, scl === 1'b1, sda === 1'b1}, 32'd3);
    check("addr_byte", 32'(slv_addr_byte), 32'({a, rw}));
    check("frames", 32'(slv_frames - fr0), ack_a ? 32'd2 : 32'd1);
    check("start_stop", 32'((slv_starts - st0) * 16 + (slv_stops - sp0)), 32'h11);
    check("scl_edges", 32'(ph_edges - pe0), ack_a ? 32'd37 : 32'd19);
    check("scl_phase_bad", 32'(ph_bad - pb0), 32'd0);
    check("sda_at_scl_edge", 32'(sda_edge_bad - sb0), 32'd0);
    check("proto_bad", 32'(proto_bad - pr0), 32'd0);
    if (ack_a && !rw) check("slv_wdata", 32'(slv_data_byte), 32'(wd));
    if (ack_a && rw) check("master_nack", 32'(slv_mnack - mn0), 32'd1);
    m_rdata = exp_rd;
    if (!keep_valid) begin
      req_valid = 1'b0;
      @(negedge clk);
      check("rsp_one_shot", 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    bit         saw;
    logic [6:0] ra;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_rw    = 1'b0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_nack", 32'(rsp_nack), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_bus", {30'd0, scl === 1'b1, sda === 1'b1}, 32'd3);

    run_txn(7'h2A, 1'b0, 8'h5A, 1'b0, 0);
    slv_tx = 8'hCC;
    run_txn(7'h2A, 1'b1, 8'h00, 1'b0, 0);
    run_txn(7'h2B, 1'b0, 8'h77, 1'b0, 0);
    slv_tx = 8'h3C;
    run_txn(7'h2A, 1'b0, 8'h81, 1'b1, 0);
    run_txn(7'h2A, 1'b1, 8'h00, 1'b0, 1);
    slv_nack_data = 1'b1;
    run_txn(7'h2A, 1'b0, 8'hF0, 1'b0, 0);
    slv_nack_data = 1'b0;
    run_txn(7'h11, 1'b1, 8'h00, 1'b0, 0);

    for (int i = 0; i < 10; i++) begin
      ra            = ($urandom_range(0, 1) == 0) ? SlvAddr : 7'($urandom);
      slv_tx        = 8'($urandom);
      slv_nack_data = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_txn(ra, 1'($urandom), 8'($urandom), 1'b0, 0);
    end
    slv_nack_data = 1'b0;

    // Abandon a write in the q0 quarter of data bit 3 (slot 14), where scl and sda are low.
    req_valid = 1'b1;
    req_addr  = 7'h2A;
    req_rw    = 1'b0;
    req_wdata = 8'hA5;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (56 * Div) @(negedge clk);
    check("pre_rst_scl_low", 32'(scl === 1'b0), 32'd1);
    check("pre_rst_sda_low", 32'(sda === 1'b0), 32'd1);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_scl", 32'(scl === 1'b1), 32'd1);
    check("async_rst_sda", 32'(sda === 1'b1), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    saw = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) saw = 1'b1;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) saw = 1'b1;
    end
    check("no_rsp_after_rst", 32'(saw), 32'd0);
    check("ready_after_rst", 32'(req_ready), 32'd1);
    check("rdata_after_rst", 32'(rsp_rdata), 32'd0);
    m_rdata = 8'h00;
    mon_en  = 1'b1;
    @(negedge clk);
    run_txn(7'h2A, 1'b0, 8'h3B, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
